// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle control unit: FSM state enum, opcode map,
// ALU operation codes and the decoded-instruction struct.
// Imported by the opcode decoder and the control FSM top.
package ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4
   } state_t;

   // Opcode map (low 4 bits of the opcode field)
   localparam logic [3:0] OP_LOAD  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SUB   = 4'b0011;
   localparam logic [3:0] OP_AND   = 4'b0100;
   localparam logic [3:0] OP_OR    = 4'b0101;

   // ALU operation select; LOAD/STORE reuse ALU_ADD for address generation
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef struct packed {
      logic       legal;
      logic       is_load;
      logic       is_store;
      logic       is_alu;
      logic [1:0] alu_op;
   } decode_t;

endpackage

// File: rtl/opcode_decoder.sv
// Purely combinational opcode classifier: opcode -> decode_t.
// Latency: 0 cycles. No handshake, no backpressure.
// Ports: opcode (in, OPCODE_W) ; dec (out, decode_t). Any set bit above bit 3
// or a low nibble outside the opcode map yields legal = 0 and all flags 0.
module opcode_decoder
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 4
) (
   input  logic [OPCODE_W-1:0] opcode,
   output decode_t             dec
);

   logic high_zero;

   assign high_zero = ((opcode >> 4) == '0);

   always_comb begin
      dec = '0;
      if (high_zero) begin
         case (opcode[3:0])
            OP_LOAD:  begin dec.legal = 1'b1; dec.is_load  = 1'b1; dec.alu_op = ALU_ADD; end
            OP_STORE: begin dec.legal = 1'b1; dec.is_store = 1'b1; dec.alu_op = ALU_ADD; end
            OP_ADD:   begin dec.legal = 1'b1; dec.is_alu   = 1'b1; dec.alu_op = ALU_ADD; end
            OP_SUB:   begin dec.legal = 1'b1; dec.is_alu   = 1'b1; dec.alu_op = ALU_SUB; end
            OP_AND:   begin dec.legal = 1'b1; dec.is_alu   = 1'b1; dec.alu_op = ALU_AND; end
            OP_OR:    begin dec.legal = 1'b1; dec.is_alu   = 1'b1; dec.alu_op = ALU_OR;  end
            default:  dec = '0;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: IDLE -> DECODE -> EXEC -> (MEM) -> (WB) -> IDLE.
// Latency: ALU 4, LOAD 4+mem wait, STORE 3+mem wait, illegal 2 cycles to ready.
// Backpressure: instr_ready only in IDLE; MEM holds its strobe until mem_ready.
// Ports: clk, rst (sync, active-high); instr_valid/instr_ready/opcode from
// fetch; mem_ready from data memory; reg_write_enable, mem_read, mem_write,
// alu_op to the datapath; illegal_op, mem_timeout pulses; retired_cnt and
// illegal_cnt wrapping counters. All strobes are Moore outputs.
// Optional macro MEM_TIMEOUT_EN: abandon a memory access after MEM_TIMEOUT
// cycles without mem_ready, pulse mem_timeout and return to IDLE unretired.
module multicycle_control_unit
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W    = 4,
   parameter int ALU_OP_W    = 2,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                reg_write_enable,
   output logic                mem_read,
   output logic                mem_write,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                illegal_op,
   output logic                mem_timeout,
   output logic [CNT_W-1:0]    retired_cnt,
   output logic [CNT_W-1:0]    illegal_cnt
);

   if (ALU_OP_W < 2) begin : g_bad_alu_w
      $fatal(1, "ALU_OP_W must be at least 2");
   end
   if (MEM_TIMEOUT < 1) begin : g_bad_timeout
      $fatal(1, "MEM_TIMEOUT must be at least 1");
   end

   state_t              state, state_nxt;
   logic [OPCODE_W-1:0] op_q;
   decode_t             dec;
   logic                retire;
   logic                illegal_seen;
   logic                timeout_hit;

   // The decoder looks at the latched opcode, so every output is a function
   // of registered state only.
   opcode_decoder #(.OPCODE_W(OPCODE_W)) u_opcode_decoder (
      .opcode (op_q),
      .dec    (dec)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   logic [TW-1:0] wait_cnt;
   logic          timeout_q;
   logic          wait_limit;

   // wait_cnt is held at 0 outside MEM, so each MEM entry restarts it.
   assign wait_limit = (wait_cnt == TW'(MEM_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         wait_cnt  <= (state == MEM && state_nxt == MEM) ? wait_cnt + TW'(1) : '0;
         timeout_q <= timeout_hit;
      end
   end

   // The abandoned access leaves MEM on the same edge, so the pulse cycle
   // already has the strobe dropped.
   assign mem_timeout = timeout_q;
`else
   assign mem_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         op_q        <= '0;
         retired_cnt <= '0;
         illegal_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && instr_valid) begin
            op_q <= opcode;
         end
         if (retire) begin
            retired_cnt <= retired_cnt + CNT_W'(1);
         end
         if (illegal_seen) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt        = state;
      retire           = 1'b0;
      illegal_seen     = 1'b0;
      timeout_hit      = 1'b0;
      instr_ready      = 1'b0;
      reg_write_enable = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      alu_op           = '0;
      illegal_op       = 1'b0;

      case (state)
         IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               state_nxt = DECODE;
            end
         end
         DECODE: begin
            if (dec.legal) begin
               state_nxt = EXEC;
            end else begin
               illegal_op   = 1'b1;
               illegal_seen = 1'b1;
               state_nxt    = IDLE;
            end
         end
         EXEC: begin
            alu_op    = ALU_OP_W'(dec.alu_op);
            state_nxt = dec.is_alu ? WB : MEM;
         end
         MEM: begin
            mem_read  = dec.is_load;
            mem_write = dec.is_store;
            // mem_ready takes priority over a timeout reached in the same cycle
            if (mem_ready) begin
               if (dec.is_load) begin
                  state_nxt = WB;
               end else begin
                  retire    = 1'b1;
                  state_nxt = IDLE;
               end
            end
`ifdef MEM_TIMEOUT_EN
            else if (wait_limit) begin
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end
`endif
         end
         WB: begin
            reg_write_enable = 1'b1;
            retire           = 1'b1;
            state_nxt        = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle FSM control unit that replaces the single-cycle combinational opcode decoder.
- Accepts one instruction per valid/ready handshake.
- Sequences it through DECODE / EXEC / MEM / WB.
- Holds memory strobes until the memory acknowledges, and flags illegal opcodes.
- Sits between the instruction fetch stage and the datapath (regfile, ALU, data memory).

Parameters:
- OPCODE_W, 4: opcode width; opcodes above 4'b0101 are illegal, and any set bit above bit 3 is illegal.
- ALU_OP_W, 2: ALU operation code width; must be ≥ 2.
- CNT_W, 16: width of the retired-instruction and illegal-opcode counters.
- MEM_TIMEOUT, 15: MEM-state wait limit in cycles; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  opcode is valid
- instr_ready  out  1  unit can accept an instruction (high only in IDLE)
- opcode  in  OPCODE_W  instruction opcode
- mem_ready  in  1  memory acknowledges the current read/write
- reg_write_enable  out  1  regfile write strobe
- mem_read  out  1  data memory read request
- mem_write  out  1  data memory write request
- alu_op  out  ALU_OP_W  ALU operation select
- illegal_op  out  1  one-cycle pulse on an illegal opcode
- mem_timeout  out  1  one-cycle timeout pulse (tied 0 without the macro)
- retired_cnt  out  CNT_W  count of completed legal instructions
- illegal_cnt  out  CNT_W  count of illegal opcodes seen

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - State goes to IDLE and the opcode register clears to 0.
  - All outputs are 0 except instr_ready, which is 1.
  - Both counters clear to 0.
  - Reset mid-instruction aborts it immediately: no strobe is issued after the reset edge and no counter increments.
- Opcode map:
  - LOAD = 0000, STORE = 0001, ADD = 0010, SUB = 0011, AND = 0100, OR = 0101.
  - Every other opcode is illegal.
- alu_op encoding:
  - ADD = 00, SUB = 01, AND = 10, OR = 11.
  - LOAD and STORE use 00 (address add).
- Output style: all outputs are Moore outputs, decoded from the state and the latched opcode.
  - alu_op is valid only in EXEC; it is 0 in all other states.
- IDLE:
  - instr_ready = 1.
  - On instr_valid && instr_ready: latch opcode, go to DECODE.
- DECODE (1 cycle):
  - Illegal opcode: illegal_op = 1 this cycle, illegal_cnt += 1, go to IDLE.
  - Legal opcode: go to EXEC.
- EXEC (1 cycle):
  - Drive alu_op.
  - LOAD/STORE go to MEM; ADD/SUB/AND/OR go to WB.
- MEM:
  - Hold mem_read (LOAD) or mem_write (STORE) high every cycle until a cycle in which mem_ready = 1.
  - On that cycle: LOAD goes to WB; STORE goes to IDLE with retired_cnt += 1.
  - mem_ready = 1 on the first MEM cycle is legal and gives zero wait.
- WB (1 cycle):
  - reg_write_enable = 1, retired_cnt += 1, go to IDLE.
- Latency, from acceptance edge to instr_ready high again:
  - ALU ops: 4 cycles.
  - LOAD: 4 cycles plus memory wait.
  - STORE: 3 cycles plus memory wait.
  - Illegal opcode: 2 cycles.
- Inputs ignored outside their states:
  - instr_valid outside IDLE (instr_ready = 0).
  - mem_ready outside MEM.
- Exclusivity: mem_read and mem_write are never both high. reg_write_enable is never high in the same cycle as either memory strobe.
- Counters wrap: 2^CNT_W−1 increments to 0.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while in MEM and restarts on every MEM entry.
  - If MEM_TIMEOUT cycles pass without mem_ready, the unit pulses mem_timeout for 1 cycle and drops the memory strobe that same cycle.
  - It then returns to IDLE without retiring and without a WB cycle.
  - If mem_ready arrives in the same cycle the limit is reached, mem_ready wins.
- Without the macro: the unit waits in MEM indefinitely and mem_timeout is constant 0.

Decomposition:
- Package ctrl_pkg holds:
  - the state enum (IDLE, DECODE, EXEC, MEM, WB);
  - opcode localparams and alu_op localparams;
  - a decode struct {legal, is_load, is_store, is_alu, alu_op}.
- Sub-module opcode_decoder: purely combinational, opcode to decode struct. It is reused by the FSM and the bench scoreboard.

Test Plan:
- Reset then ADD: rst for 2 cycles, then opcode = 0010 with instr_valid → EXEC alu_op = 00; reg_write_enable high exactly 1 cycle, 3 cycles after accept; retired_cnt = 1; instr_ready back after 4 cycles.
- LOAD with 3-cycle memory wait: opcode = 0000, mem_ready asserted on the 3rd MEM cycle → mem_read high exactly 3 cycles, then WB, then retired_cnt increments. Repeat STORE 0001 with mem_ready on the first MEM cycle → mem_write high 1 cycle, no reg_write_enable.
- Illegal opcode 1111 → illegal_op pulses in DECODE, illegal_cnt = 1, no strobes, instr_ready high 2 cycles after accept. Back-to-back SUB 0011 then executes with alu_op = 01.
- Reset mid-MEM: LOAD stalled with mem_ready = 0, rst pulsed → next cycle all outputs 0, instr_ready = 1, counters 0.
- Ignored inputs and wrap: instr_valid held high during EXEC does not re-accept; mem_ready pulse in IDLE has no effect. With CNT_W = 2, 5 ADDs → retired_cnt = 1.
- Timeout (MEM_TIMEOUT_EN, MEM_TIMEOUT = 4): STORE with mem_ready low → mem_write high 4 cycles, mem_timeout 1-cycle pulse, return to IDLE, retired_cnt unchanged. Without the macro, the unit is still in MEM after 100 cycles.
